// File: rtl/rf_write_controller_pkg.sv
// Shared types and constants for the register-file write-port controller.
// Covers the init sweep, the core/debug arbitration grants and register names.
package rf_write_controller_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        G_NONE,
        G_INIT,
        G_CORE,
        G_DBG,
        G_FORCE
    } grant_e;

    localparam logic [4:0] REG_X0   = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd2;
    localparam logic [4:0] REG_LAST = 5'd31;

    localparam logic [31:0] SP_INIT_DEF      = 32'h0000_03FC;
    localparam int unsigned STARVE_LIMIT_DEF = 8;

    function automatic logic [31:0] init_value(
        input logic [4:0]  idx,
        input logic [31:0] sp
    );
        return (idx == REG_SP) ? sp : 32'h0;
    endfunction

endpackage

// File: rtl/rf_write_controller_if.sv
// Core writeback, debug write handshake and register-file write bundle.
// The controller takes the slave side; requesters and the file sit on master.
interface rf_write_controller_if;
    logic        core_wenable;
    logic [4:0]  core_rd;
    logic [31:0] core_wdata;
    logic        dbg_wvalid;
    logic        dbg_wready;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_wdata;
    logic        rf_wenable;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        core_stall;
    logic        init_done;

    modport slave (
        input  core_wenable,
        input  core_rd,
        input  core_wdata,
        input  dbg_wvalid,
        input  dbg_rd,
        input  dbg_wdata,
        output dbg_wready,
        output rf_wenable,
        output rf_waddr,
        output rf_wdata,
        output core_stall,
        output init_done
    );

    modport master (
        output core_wenable,
        output core_rd,
        output core_wdata,
        output dbg_wvalid,
        output dbg_rd,
        output dbg_wdata,
        input  dbg_wready,
        input  rf_wenable,
        input  rf_waddr,
        input  rf_wdata,
        input  core_stall,
        input  init_done
    );
endinterface

// File: rtl/rf_write_controller.sv
// Owns the register file write port: post-reset init sweep of x1..x31,
// then core/debug arbitration with starvation protection for debug.
module rf_write_controller
    import rf_write_controller_pkg::*;
#(
    parameter logic [31:0] SP_INIT      = SP_INIT_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic                  clk,
    input logic                  rst,
    rf_write_controller_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e     state;
    logic [4:0] init_idx;
    logic [7:0] starve_cnt;
    grant_e     grant;
    logic       core_req;
    logic       forced;

    assign core_req = bus.core_wenable && (bus.core_rd != REG_X0);
    assign forced   = bus.dbg_wvalid && (starve_cnt == LIMIT);

    always_comb begin
        grant = G_NONE;
        if (rst) begin
            grant = G_NONE;
        end else if (state == S_INIT) begin
            grant = G_INIT;
        end else if (forced) begin
            grant = G_FORCE;
        end else if (core_req) begin
            grant = G_CORE;
        end else if (bus.dbg_wvalid) begin
            grant = G_DBG;
        end
    end

    // Outputs are combinational so the file captures them on the falling edge.
    always_comb begin
        bus.rf_wenable = 1'b0;
        bus.rf_waddr   = 5'd0;
        bus.rf_wdata   = 32'h0;
        bus.dbg_wready = 1'b0;
        bus.core_stall = 1'b0;
        bus.init_done  = !rst && (state == S_RUN);
        unique case (grant)
            G_NONE: begin
                bus.core_stall = rst;
            end
            G_INIT: begin
                bus.rf_wenable = 1'b1;
                bus.rf_waddr   = init_idx;
                bus.rf_wdata   = init_value(init_idx, SP_INIT);
                bus.core_stall = 1'b1;
            end
            G_CORE: begin
                bus.rf_wenable = 1'b1;
                bus.rf_waddr   = bus.core_rd;
                bus.rf_wdata   = bus.core_wdata;
            end
            G_DBG, G_FORCE: begin
                bus.dbg_wready = 1'b1;
                bus.core_stall = (grant == G_FORCE);
                if (bus.dbg_rd != REG_X0) begin
                    bus.rf_wenable = 1'b1;
                    bus.rf_waddr   = bus.dbg_rd;
                    bus.rf_wdata   = bus.dbg_wdata;
                end
            end
            default: begin
                bus.core_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            init_idx   <= 5'd1;
            starve_cnt <= 8'd0;
        end else begin
            unique case (state)
                S_INIT: begin
                    init_idx <= init_idx + 5'd1;
                    if (init_idx == REG_LAST) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Only a debug request losing to the core accumulates.
                    if (grant == G_CORE && bus.dbg_wvalid) begin
                        if (starve_cnt < LIMIT) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end else begin
                        starve_cnt <= 8'd0;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule
